// File: rtl/fft_pkg.sv
// fft_pkg: shared state type, default sizing and width helpers for the FFT stage sequencer
package fft_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_seq_state_t;

    localparam int LOG2N_DEF      = 4;
    localparam int MEM_RD_LAT_DEF = 1;
    localparam int BFLY_LAT_DEF   = 3;
    localparam int N              = 1 << LOG2N_DEF;
    localparam int L              = MEM_RD_LAT_DEF + BFLY_LAT_DEF;

    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// fft_addr_delay: fixed-depth shift register carrying {valid, addr_a, addr_b} to the write-back port
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = L,
    parameter int AW    = LOG2N_DEF
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    output logic          late_valid,
    output logic [AW-1:0] late_addr_a,
    output logic [AW-1:0] late_addr_b
);

    logic [2*AW:0] sr [DEPTH];

    // shift the issued butterfly forward one slot per cycle; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {valid, addr_a, addr_b};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign {late_valid, late_addr_a, late_addr_b} = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks all radix-2 DIT stages, issuing one butterfly per cycle and its delayed write-back.
// Optional inverse-transform support (inverse / tw_conj ports) is built when FFT_SEQ_IFFT_EN is defined.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N      = LOG2N_DEF,
    parameter int MEM_RD_LAT = MEM_RD_LAT_DEF,
    parameter int BFLY_LAT   = BFLY_LAT_DEF
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
`ifdef FFT_SEQ_IFFT_EN
    input  logic                        inverse,
    output logic                        tw_conj,
`endif
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [LOG2N-1:0]            rd_addr_a,
    output logic [LOG2N-1:0]            rd_addr_b,
    output logic [LOG2N-2:0]            tw_addr,
    output logic                        wr_en,
    output logic [LOG2N-1:0]            wr_addr_a,
    output logic [LOG2N-1:0]            wr_addr_b,
    output logic [stage_w(LOG2N)-1:0]   stage
);

    localparam int AW  = LOG2N;
    localparam int KW  = LOG2N - 1;
    localparam int SW  = stage_w(LOG2N);
    localparam int LAT = MEM_RD_LAT + BFLY_LAT;
    localparam int DW  = cnt_w(LAT);

    fft_seq_state_t state, nxt;
    logic [KW-1:0]  k;
    logic [DW-1:0]  dcnt;
    logic [SW-1:0]  stage_cnt;
    logic [AW-1:0]  half, pos, grp, addr_a, addr_b;
    logic [KW-1:0]  tw;
    logic           last_k, last_drain, last_stage;

    assign last_k     = k == {KW{1'b1}};
    assign last_drain = dcnt == DW'(LAT - 1);
    assign last_stage = stage_cnt == SW'(LOG2N - 1);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state: run N/2 butterflies, drain the pipeline, repeat per stage, then signal completion
    always_comb begin
        nxt = state == IDLE  ? (start ? RUN : IDLE) :
              state == RUN   ? (last_k ? DRAIN : RUN) :
              state == DRAIN ? (last_drain ? (last_stage ? DONE : RUN) : DRAIN) :
                               IDLE;
    end

    // butterfly index, drain length and stage counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            dcnt      <= '0;
            stage_cnt <= '0;
        end else begin
            k         <= (state == RUN) ? k + KW'(1) : '0;
            dcnt      <= (state == DRAIN) ? dcnt + DW'(1) : '0;
            stage_cnt <= (state == DRAIN && last_drain && !last_stage) ? stage_cnt + SW'(1) :
                         (state == RUN || state == DRAIN) ? stage_cnt : '0;
        end
    end

    // in-place DIT addressing: pairs are half apart inside groups of 2*half, twiddle stride shrinks per stage
    always_comb begin
        half   = AW'(1) << stage_cnt;
        pos    = {1'b0, k} & (half - AW'(1));
        grp    = {1'b0, k} >> stage_cnt;
        addr_a = ((grp << stage_cnt) << 1) | pos;
        addr_b = addr_a + half;
        tw     = KW'({pos, {KW{1'b0}}} >> stage_cnt);
    end

    // outputs decoded from state; addresses held at zero outside issue cycles
    always_comb begin
        rd_en     = state == RUN;
        busy      = state != IDLE;
        done      = state == DONE;
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? addr_b : '0;
        tw_addr   = rd_en ? tw : '0;
        stage     = stage_cnt;
    end

    fft_addr_delay #(.DEPTH(LAT), .AW(AW)) u_wb (
        .clk         (clk),
        .rst         (rst),
        .valid       (rd_en),
        .addr_a      (rd_addr_a),
        .addr_b      (rd_addr_b),
        .late_valid  (wr_en),
        .late_addr_a (wr_addr_a),
        .late_addr_b (wr_addr_b)
    );

`ifdef FFT_SEQ_IFFT_EN
    logic inv_q;

    // hold the transform direction from start acceptance until DONE is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          inv_q <= 1'b0;
        else if (state == IDLE && start)  inv_q <= inverse;
        else if (state == DONE)           inv_q <= 1'b0;
    end

    assign tw_conj = inv_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of stage walk, addressing, write-back alignment and abuse cases
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [2:0] tw_addr;
    logic [1:0] stage;
`ifdef FFT_SEQ_IFFT_EN
    logic       inverse = 1'b0;
    logic       tw_conj;
`endif

    int n_chk = 0;
    int n_pass = 0;

    int vc[9] = '{1, 2, 8, 14, 20, 28, 29, 42, 44};
    int va[9] = '{0, 2, 14, 1, 13, 3, 8, 5, 7};
    int vb[9] = '{1, 3, 15, 3, 15, 7, 12, 13, 15};
    int vt[9] = '{0, 0, 0, 4, 4, 6, 0, 5, 7};

    int rd_a[64];
    int rd_b[64];

    fft_stage_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_SEQ_IFFT_EN
        .inverse   (inverse),
        .tw_conj   (tw_conj),
`endif
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int in_run(input int c);
        if (c < 1) return 0;
        return ((c - 1) / 12 < 4 && (c - 1) % 12 < 8) ? 1 : 0;
    endfunction

    function automatic int exp_stage(input int c);
        return (c >= 1 && c <= 48) ? (c - 1) / 12 : (c == 49) ? 3 : 0;
    endfunction

    initial begin
        int wr_cnt, first, dn, wrs, bsy;

        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ctl", int'({busy, done, rd_en, wr_en}), 0);
            check("idle_addr", int'(rd_addr_a) + int'(rd_addr_b) + int'(tw_addr) +
                  int'(wr_addr_a) + int'(wr_addr_b) + int'(stage), 0);
        end

        wr_cnt = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 56; c++) begin
            @(negedge clk); start = 1'b0;
            check("rd_en", int'(rd_en), in_run(c));
            check("busy", int'(busy), (c <= 49) ? 1 : 0);
            check("done", int'(done), (c == 49) ? 1 : 0);
            check("stage", int'(stage), exp_stage(c));
            check("wr_en", int'(wr_en), in_run(c - 4));
            rd_a[c] = int'(rd_addr_a);
            rd_b[c] = int'(rd_addr_b);
            if (c >= 5 && in_run(c - 4) == 1) begin
                check("wr_addr_a", int'(wr_addr_a), rd_a[c-4]);
                check("wr_addr_b", int'(wr_addr_b), rd_b[c-4]);
            end
            if (wr_en) wr_cnt++;
            if (c == 13) check("raw_order", wr_cnt, 8);
            for (int j = 0; j < 9; j++) begin
                if (vc[j] == c) begin
                    check("vec_a", int'(rd_addr_a), va[j]);
                    check("vec_b", int'(rd_addr_b), vb[j]);
                    check("vec_tw", int'(tw_addr), vt[j]);
                end
                if (vc[j] + 4 == c) begin
                    check("vec_wr_a", int'(wr_addr_a), va[j]);
                    check("vec_wr_b", int'(wr_addr_b), vb[j]);
                end
            end
        end
        check("wr_total", wr_cnt, 32);

        first = -1;
        dn = 0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) dn++;
            if (c == 1) check("hold_rd1", int'(rd_en), 1);
            if (c == 9) check("hold_rd9", int'(rd_en), 0);
            if (c == 49) check("hold_done", int'(done), 1);
            if (c == 50) check("hold_busy", int'(busy), 0);
            if (c >= 50 && rd_en && first < 0) first = c;
        end
        check("hold_first_rd", first, 51);
        check("hold_done_cnt", dn, 1);

        start = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk); start = 1'b0;
        end
        @(posedge clk); #3 rst = 1'b1;
        #1 check("rst_now", int'({busy, done, rd_en, wr_en}), 0);
        @(negedge clk); rst = 1'b0;
        wrs = 0;
        dn = 0;
        bsy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (wr_en) wrs++;
            if (done) dn++;
            if (busy) bsy++;
        end
        check("rst_no_wr", wrs, 0);
        check("rst_no_done", dn, 0);
        check("rst_no_busy", bsy, 0);

`ifdef FFT_SEQ_IFFT_EN
        for (int r = 0; r < 2; r++) begin
            int bad, rds;
            bad = 0;
            rds = 0;
            @(negedge clk); start = 1'b1; inverse = (r == 0);
            for (int c = 1; c <= 50; c++) begin
                @(negedge clk); start = 1'b0; inverse = (r != 0);
                if (rd_en) begin
                    rds++;
                    if (int'(tw_conj) != ((r == 0) ? 1 : 0)) bad++;
                end
                if (c == 50) check("conj_after", int'(tw_conj), 0);
            end
            check("conj_rd", bad, 0);
            check("conj_cnt", rds, 32);
            inverse = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Controls an in-place radix-2 DIT FFT over one shared butterfly unit and a dual-port sample RAM. On a start pulse it walks all log2(N) stages and issues one butterfly per cycle: RAM read addresses A/B and a twiddle ROM index. It delays the addresses to match RAM read latency plus butterfly pipeline latency, then issues the write-back. Input samples are pre-loaded into RAM in bit-reversed order by the load logic; this block does not touch data.

Parameters:
LOG2N, 4, log2 of FFT length N (N=16 default); legal 2..10
MEM_RD_LAT, 1, sample RAM synchronous read latency in cycles
BFLY_LAT, 3, butterfly unit input-to-output latency in cycles
L is defined as MEM_RD_LAT+BFLY_LAT, the total issue-to-writeback delay (4 by default).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to run a full FFT; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last write-back has completed
rd_en  out  1  RAM read strobe (one butterfly issued)
rd_addr_a  out  LOG2N  RAM read address of butterfly input A
rd_addr_b  out  LOG2N  RAM read address of butterfly input B
tw_addr  out  LOG2N-1  twiddle ROM index, registered with rd_en
wr_en  out  1  RAM write strobe for butterfly outputs
wr_addr_a  out  LOG2N  write address for output A
wr_addr_b  out  LOG2N  write address for output B
stage  out  $clog2(LOG2N)  current stage index, for debug and scaling

Behaviour:
- Reset values: all outputs 0; state IDLE; stage counter and butterfly counter k are 0; delay-line valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. The first rd_en occurs in the next cycle.
- RUN: rd_en=1 every cycle, k runs 0..N/2-1. After k=N/2-1, go to DRAIN.
- DRAIN: lasts exactly L cycles, with rd_en=0. It guarantees stage s writes finish before stage s+1 reads (no RAW hazard).
- DRAIN exit: go to RUN with stage+1 and k=0, unless stage=LOG2N-1, in which case go to DONE.
- DONE: done=1 for one cycle, then return to IDLE. busy=1 in RUN, DRAIN and DONE.
- Each stage takes N/2+L cycles. With start sampled at cycle 0, done is high in cycle 1+LOG2N*(N/2+L); this is cycle 49 for the defaults.
- Address math, for stage s and index k:
  - half = 1<<s
  - pos = k & (half-1)
  - grp = k>>s
  - rd_addr_a = (grp<<(s+1)) | pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos << (LOG2N-1-s)
- Address width: all address math is unsigned and exactly LOG2N bits wide; it never wraps within a legal k range.
- Write-back: wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly L cycles.
- start while busy: ignored, with no effect on the sequence.
- Reset mid-operation: returns to IDLE immediately. Pending write-backs are discarded (wr_en=0), and done does not pulse.
- A start in the same cycle that done is high is ignored (state is DONE, not IDLE).

Optional Feature:
FFT_SEQ_IFFT_EN
- With the macro defined: adds input port inverse (1 bit) and output port tw_conj (1 bit).
  - inverse is latched when start is accepted.
  - tw_conj equals the latched value and is aligned with tw_addr, so the twiddle path conjugates it for IFFT.
  - The latch clears on reset and when DONE is left.
- Without the macro: neither port exists and the behaviour is forward-only.

Decomposition:
- Shared package fft_pkg:
  - FSM state enum fft_seq_state_t (IDLE/RUN/DRAIN/DONE)
  - localparams N and L
  - address-width helper constants
- One natural sub-module: fft_addr_delay, a parameterised depth-L shift register carrying {valid, addr_a, addr_b}.
  - It has asynchronous clear on rst.
  - The sequencer instantiates it for write-back alignment.

Test Plan:
1. Reset and idle: assert rst mid-cycle, release, hold start=0 for 20 cycles -> all outputs 0, busy=0.
2. Address sequence, defaults (LOG2N=4): pulse start at cycle 0 -> rd_en high cycles 1-8, 13-20, 25-32, 37-44.
   - Stage 0, k=0: (a,b,tw)=(0,1,0); k=1: (2,3,0).
   - Stage 1, k=1: (1,3,4).
   - Stage 2, k=3: (3,7,6).
   - Stage 3, k=5: (5,13,5).
3. Write-back alignment: every wr_en pulse occurs exactly 4 cycles after its rd_en, with identical addresses.
   - There are 32 wr_en pulses in total.
   - No cycle has a stage-(s+1) read before the final stage-s write.
4. Completion timing: done is a single pulse in cycle 49; busy falls in cycle 50; stage reads 3 during the last run.
5. Abuse: start held high throughout -> second FFT starts only from IDLE (its first rd_en is at cycle 51). Separately, rst asserted at cycle 15 -> immediate IDLE with no further wr_en and no done pulse.
6. With FFT_SEQ_IFFT_EN defined: start with inverse=1 -> tw_conj=1 on every rd_en cycle, and 0 after done; rerun with inverse=0 -> tw_conj=0 throughout.
